// File: rtl/addsub_pkg.sv
// Shared types and sizing helpers for the digit-serial adder/subtractor.
package addsub_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic int nslice(input int width, input int digit);
    return width / digit;
  endfunction

  // Slice index width; a single-slice build still needs a 1-bit counter.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// DIGIT-bit combinational ripple adder; exposes the carry into its MSB
// so the top can form signed overflow on the final slice.
module addsub_slice #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial add/sub with valid/ready on both sides; one DIGIT slice per clock.
//   state | meaning
//   IDLE  | waiting for operands (in_ready high once out of reset)
//   RUN   | adding slice idx into s
//   DONE  | result and flags held until out_ready
module addsub_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             k,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);
  import addsub_pkg::*;

  localparam int NSLICE = nslice(WIDTH, DIGIT);
  localparam int IW     = idx_width(NSLICE);
  localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] xr, yr, s_nxt;
  logic             carry;
  logic [IW-1:0]    idx;
  logic             armed;
  logic [DIGIT-1:0] a_sl, b_sl, sum_sl;
  logic             cout_sl, cmsb_sl;
  logic             accept;

  always_comb begin
    a_sl = xr[int'(idx)*DIGIT +: DIGIT];
    b_sl = yr[int'(idx)*DIGIT +: DIGIT];
  end

  addsub_slice #(.DIGIT(DIGIT)) u_slice (
    .a    (a_sl),
    .b    (b_sl),
    .cin  (carry),
    .sum  (sum_sl),
    .cout (cout_sl),
    .c_msb(cmsb_sl)
  );

  always_comb begin
    s_nxt = s;
    s_nxt[int'(idx)*DIGIT +: DIGIT] = sum_sl;
  end

  // armed keeps in_ready low for the first cycle after reset releases.
  assign accept = (state == IDLE) && armed && in_valid;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = armed;
        if (accept) state_nxt = RUN;
      end
      RUN:  if (idx == LAST) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      armed    <= 1'b0;
      xr       <= '0;
      yr       <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      s        <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
      if (accept) begin
        xr    <= x;
        yr    <= y ^ {WIDTH{k}};
        carry <= k;
        idx   <= '0;
      end else if (state == RUN) begin
        s     <= s_nxt;
        carry <= cout_sl;
        idx   <= idx + IW'(1);
        if (idx == LAST) begin
          carryout <= cout_sl;
          overflow <= cout_sl ^ cmsb_sl;
          zero     <= (s_nxt == '0);
        end
      end
    end
  end

endmodule

// File: doc/addsub_serial.md
# addsub_serial

Parametrised digit-serial adder/subtractor with a valid/ready handshake on both sides. It is the sequential successor to the team's 4-bit ripple add/sub stage. It processes a WIDTH-bit operation in DIGIT-bit slices, one slice per clock, and reports carry, signed overflow and zero flags. It sits between an operand source and a result consumer, either of which may stall.

## Interface
- WIDTH, 16: operand and result width; must be a multiple of DIGIT.
- DIGIT, 4: bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH.
- Derived: NSLICE = WIDTH/DIGIT.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- in_valid  in  1  operand source has x, y, k valid.
- in_ready  out  1  block can accept an operation.
- x  in  WIDTH  operand A.
- y  in  WIDTH  operand B.
- k  in  1  mode: 0 = x+y, 1 = x−y (two's complement).
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer takes the result.
- s  out  WIDTH  sum/difference.
- carryout  out  1  final carry. For subtract, 1 means no borrow (x ≥ y unsigned).
- overflow  out  1  signed overflow: carry into MSB XOR carry out of MSB.
- zero  out  1  s == 0.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - in_ready = 1.
  - When in_valid is high, latch x, latch (y XOR {WIDTH{k}}), set the carry register to k, clear the slice index, and go to RUN.
- RUN:
  - Each cycle, slice i (bits i·DIGIT+DIGIT−1 : i·DIGIT) is added with the carry register.
  - The slice result is written to s, the carry register is updated, and the index increments.
  - After slice NSLICE−1: capture carryout and overflow, compute zero, and go to DONE.
- DONE:
  - out_valid = 1; s and the flags hold stable.
  - When out_ready is high, go to IDLE.
- in_ready is high only in IDLE. Operands offered in RUN or DONE are not accepted.
- x, y and k are sampled only at acceptance; later input changes have no effect.
- All arithmetic is modulo 2^WIDTH. Flags are defined exactly as in Interface.

## Timing
- While resetn is low, and after the first edge where it is sampled low:
  - in_ready = 0, out_valid = 0.
  - s = 0, carryout = 0, overflow = 0, zero = 0.
- in_ready = 1 starting the cycle after resetn is sampled high.
- Accept edge E0 is the edge with in_valid && in_ready.
- out_valid rises after edge E_NSLICE, i.e. latency = NSLICE cycles. With NSLICE = 1, out_valid is high one cycle after accept.
- Result handoff is the edge with out_valid && out_ready. The state is IDLE after that edge.
- Peak throughput is one operation per NSLICE+2 cycles with out_ready held high.
- out_ready high outside DONE is ignored. in_valid held high across DONE starts the next operation only once the block is back in IDLE.
- resetn low in RUN or DONE aborts the operation: no out_valid is ever produced for it, and the block returns to IDLE.
- s may show partial bits during RUN. Consumers use s only when out_valid is high.

## Structure
- Package addsub_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - constants/functions for NSLICE and the slice-index width ($clog2(NSLICE), minimum 1).
- Sub-module addsub_slice: DIGIT-bit combinational ripple adder.
  - Inputs: a, b, cin.
  - Outputs: sum, cout, and c_msb (carry into the slice MSB, used for overflow on the last slice).
  - Built from per-bit full-adder equations.
- Top module: FSM, operand/result registers, carry register, slice index, flag logic.

## Test plan
All scenarios use WIDTH=16, DIGIT=4 unless stated.
- Add 0x1234 + 0x0FCD, k=0 → s=0x2201, carryout=0, overflow=0, zero=0; out_valid exactly 4 cycles after accept.
- Sub 0x0005 − 0x0005 → s=0x0000, carryout=1, zero=1, overflow=0. Sub 0x0003 − 0x0005 → s=0xFFFE, carryout=0, overflow=0, zero=0.
- Add 0x7FFF + 0x0001 → s=0x8000, overflow=1, carryout=0. Add 0xFFFF + 0x0001 → s=0x0000, carryout=1, zero=1, overflow=0. Sub 0x8000 − 0x0001 → s=0x7FFF, overflow=1.
- Hold out_ready low for 5 cycles in DONE while in_valid is high with new operands → s and flags stable, in_ready=0. After out_ready goes high, the new operation is accepted in IDLE and completes correctly.
- Assert resetn low during RUN slice 2 → outputs 0 after that edge, out_valid never asserts for the aborted operation, and in_ready=1 one cycle after resetn goes high.
- Re-run the first scenario with DIGIT=16 (latency 1) and DIGIT=1 (latency 16) → identical results and flags.
